mem_stage: RTL and testbench

Memory-access pipeline stage. It accepts instructions from EX over the valid/allowin handshake and waits for the data SRAM response on loads. It extracts and extends load data, then hands the result to WB as `{rf_we, rf_waddr, rf_wdata, pc}` over the same handshake. It also drives the forwarding/blocking bus that ID reads for hazard resolution.

---
 rtl/mem_stage_if.sv | 42 ++++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and data bundle around the MEM pipeline stage: EX input, data SRAM response,
// WB output and the forwarding bus read by ID.
interface mem_stage_if #(
   parameter int unsigned EX_TO_MEM_WIDTH = 76,
   parameter int unsigned MEM_TO_WB_WIDTH = 70
);
   logic                       ex_to_mem_valid;
   logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_wire;
   logic                       mem_allowin;
   logic                       data_sram_data_ok;
   logic [31:0]                data_sram_rdata;
   logic                       wb_allowin;
   logic                       mem_to_wb_valid;
   logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_wire;
   logic [38:0]                mem_rf_zip;

   // Surrounding pipeline / environment side.
   modport master (
      output ex_to_mem_valid,
      output ex_to_mem_wire,
      output data_sram_data_ok,
      output data_sram_rdata,
      output wb_allowin,
      input  mem_allowin,
      input  mem_to_wb_valid,
      input  mem_to_wb_wire,
      input  mem_rf_zip
   );

   // MEM stage side.
   modport slave (
      input  ex_to_mem_valid,
      input  ex_to_mem_wire,
      input  data_sram_data_ok,
      input  data_sram_rdata,
      input  wb_allowin,
      output mem_allowin,
      output mem_to_wb_valid,
      output mem_to_wb_wire,
      output mem_rf_zip
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the load response, extracts/extends load data and hands the
// result to WB. Define MEM_STAGE_FWD_EN to drive the forwarding/blocking bus; otherwise it is 0.
module mem_stage #(
   parameter int unsigned EX_TO_MEM_WIDTH = 76,
   parameter int unsigned MEM_TO_WB_WIDTH = 70
) (
   input logic          clk,
   input logic          reset,
   mem_stage_if.slave   bus
);

   logic                       mem_valid_q, mem_valid_d;
   logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_reg_q, ex_to_mem_reg_d;
   logic                       ld_done_q, ld_done_d;
   logic [31:0]                rdata_buf_q, rdata_buf_d;

   logic        res_from_mem;
   logic [4:0]  ld_op;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] alu_result;
   logic [31:0] pc;

   assign res_from_mem = ex_to_mem_reg_q[75];
   assign ld_op        = ex_to_mem_reg_q[74:70];
   assign rf_we        = ex_to_mem_reg_q[69];
   assign rf_waddr     = ex_to_mem_reg_q[68:64];
   assign alu_result   = ex_to_mem_reg_q[63:32];
   assign pc           = ex_to_mem_reg_q[31:0];

   logic mem_ready_go;
   logic mem_allowin;
   logic mem_to_wb_valid;
   logic handoff;
   logic ld_wait;

   always_comb begin
      mem_ready_go    = ~res_from_mem | ld_done_q | bus.data_sram_data_ok;
      mem_allowin     = ~mem_valid_q | (mem_ready_go & bus.wb_allowin);
      mem_to_wb_valid = mem_valid_q & mem_ready_go;
      handoff         = mem_to_wb_valid & bus.wb_allowin;
      ld_wait         = mem_valid_q & res_from_mem & ~ld_done_q;
   end

   always_comb begin
      mem_valid_d     = mem_valid_q;
      ex_to_mem_reg_d = ex_to_mem_reg_q;
      ld_done_d       = ld_done_q;
      rdata_buf_d     = rdata_buf_q;

      if (mem_allowin) begin
         mem_valid_d = bus.ex_to_mem_valid;
      end
      if (bus.ex_to_mem_valid && mem_allowin) begin
         ex_to_mem_reg_d = bus.ex_to_mem_wire;
      end

      // A response that is consumed in the same cycle never needs buffering.
      if (handoff) begin
         ld_done_d = 1'b0;
      end else if (ld_wait && bus.data_sram_data_ok) begin
         ld_done_d   = 1'b1;
         rdata_buf_d = bus.data_sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid_q     <= 1'b0;
         ex_to_mem_reg_q <= '0;
         ld_done_q       <= 1'b0;
         rdata_buf_q     <= '0;
      end else begin
         mem_valid_q     <= mem_valid_d;
         ex_to_mem_reg_q <= ex_to_mem_reg_d;
         ld_done_q       <= ld_done_d;
         rdata_buf_q     <= rdata_buf_d;
      end
   end

   logic [31:0] raw_word;
   logic [1:0]  off;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;

   always_comb begin
      raw_word = ld_done_q ? rdata_buf_q : bus.data_sram_rdata;
      off      = alu_result[1:0];

      unique case (off)
         2'd0: byte_lane = raw_word[7:0];
         2'd1: byte_lane = raw_word[15:8];
         2'd2: byte_lane = raw_word[23:16];
         2'd3: byte_lane = raw_word[31:24];
         default: byte_lane = raw_word[7:0];
      endcase
      half_lane = off[1] ? raw_word[31:16] : raw_word[15:0];

      // ld_op = {ld_b, ld_h, ld_w, ld_bu, ld_hu}
      load_data = raw_word;
      if (ld_op[4]) begin
         load_data = {{24{byte_lane[7]}}, byte_lane};
      end else if (ld_op[3]) begin
         load_data = {{16{half_lane[15]}}, half_lane};
      end else if (ld_op[2]) begin
         load_data = raw_word;
      end else if (ld_op[1]) begin
         load_data = {24'b0, byte_lane};
      end else if (ld_op[0]) begin
         load_data = {16'b0, half_lane};
      end

      rf_wdata = res_from_mem ? load_data : alu_result;
   end

   logic [MEM_TO_WB_WIDTH-1:0] wb_payload;

   assign wb_payload          = {rf_we, rf_waddr, rf_wdata, pc};
   assign bus.mem_allowin     = mem_allowin;
   assign bus.mem_to_wb_valid = mem_to_wb_valid;
   assign bus.mem_to_wb_wire  = wb_payload;

`ifdef MEM_STAGE_FWD_EN
   logic mem_blocking;

   assign mem_blocking = mem_valid_q & res_from_mem & ~mem_ready_go;
   // Whole bus is qualified so an empty stage never advertises a stale destination.
   assign bus.mem_rf_zip = mem_valid_q ? {mem_blocking, rf_we, rf_waddr, rf_wdata} : 39'b0;
`else
   assign bus.mem_rf_zip = 39'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-cycle vector table plus a hand-written late-load sequence.
module tb_mem_stage;

   localparam logic [4:0] NOLD  = 5'b00000;
   localparam logic [4:0] LD_B  = 5'b10000;
   localparam logic [4:0] LD_H  = 5'b01000;
   localparam logic [4:0] LD_W  = 5'b00100;
   localparam logic [4:0] LD_BU = 5'b00010;
   localparam logic [4:0] LD_HU = 5'b00001;

`ifdef MEM_STAGE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_stage_if #(.EX_TO_MEM_WIDTH(76), .MEM_TO_WB_WIDTH(70)) bus ();

   mem_stage #(.EX_TO_MEM_WIDTH(76), .MEM_TO_WB_WIDTH(70)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        rst;
      logic        exv;
      logic [75:0] exw;
      logic        dok;
      logic [31:0] rd;
      logic        wba;
      logic        e_allow;
      logic        e_ov;
      logic        chk_wire;
      logic [69:0] e_wire;
      logic        chk_zip;
      logic [38:0] e_zip;
   } vec_t;

   vec_t v[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [75:0] exw(logic res, logic [4:0] op, logic we, logic [4:0] wa,
                                       logic [31:0] alu, logic [31:0] pc);
      return {res, op, we, wa, alu, pc};
   endfunction

   function automatic logic [69:0] wbw(logic we, logic [4:0] wa, logic [31:0] wd,
                                       logic [31:0] pc);
      return {we, wa, wd, pc};
   endfunction

   function automatic logic [38:0] zp(logic blk, logic we, logic [4:0] wa, logic [31:0] wd);
      return {blk, we, wa, wd};
   endfunction

   function automatic vec_t mk(logic rst, logic exv, logic [75:0] w, logic dok, logic [31:0] rd,
                               logic wba, logic ea, logic eov, logic cw, logic [69:0] ew,
                               logic cz, logic [38:0] ez);
      vec_t r;
      r.rst = rst;  r.exv = exv;  r.exw = w;  r.dok = dok;  r.rd = rd;  r.wba = wba;
      r.e_allow = ea;  r.e_ov = eov;  r.chk_wire = cw;  r.e_wire = ew;
      r.chk_zip = cz;  r.e_zip = ez;
      return r;
   endfunction

   // Empty stage; optionally a new instruction is offered from EX.
   function automatic vec_t idle(logic exv, logic [75:0] w, logic dok, logic [31:0] rd,
                                 logic cz);
      return mk(1'b0, exv, w, dok, rd, 1'b1, 1'b1, 1'b0, 1'b0, '0, cz, '0);
   endfunction

   task automatic check(string what, int idx, logic [69:0] act, logic [69:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h expected %h", what, idx, act, exp);
      end
   endtask

   initial begin
      logic [69:0] w;
      logic [38:0] z;
      logic [38:0] ez;
      int          stalls;
      bit          got;

      // ALU op, one cycle in MEM
      v.push_back(idle(1'b0, '0, 1'b0, 32'h0, 1'b1));
      v.push_back(idle(1'b1, exw(1'b0, NOLD, 1'b1, 5'd5, 32'h1234, 32'h1000), 1'b0, 32'h0, 1'b0));
      v.push_back(mk(0, 0, '0, 0, 32'h0, 1, 1, 1, 1, wbw(1, 5'd5, 32'h1234, 32'h1000),
                     1, zp(0, 1, 5'd5, 32'h1234)));
      v.push_back(idle(1'b0, '0, 1'b0, 32'h0, 1'b0));
      // ALU op held under WB stall
      v.push_back(idle(1'b1, exw(1'b0, NOLD, 1'b1, 5'd7, 32'hCAFE, 32'h1004), 1'b0, 32'h0, 1'b0));
      w = wbw(1, 5'd7, 32'hCAFE, 32'h1004);
      z = zp(0, 1, 5'd7, 32'hCAFE);
      v.push_back(mk(0, 0, '0, 0, 32'h0, 0, 0, 1, 1, w, 1, z));
      v.push_back(mk(0, 0, '0, 0, 32'h0, 0, 0, 1, 1, w, 1, z));
      v.push_back(mk(0, 0, '0, 0, 32'h0, 1, 1, 1, 1, w, 1, z));
      v.push_back(idle(1'b0, '0, 1'b0, 32'h0, 1'b0));
      // ld_b off=3, data_ok three cycles late
      v.push_back(idle(1'b1, exw(1'b1, LD_B, 1'b1, 5'd9, 32'h2003, 32'h1008), 1'b0, 32'h0, 1'b0));
      for (int i = 0; i < 3; i++) begin
         v.push_back(mk(0, 0, '0, 0, 32'h0, 1, 0, 0, 0, '0, 1, zp(1, 1, 5'd9, 32'h0)));
      end
      v.push_back(mk(0, 0, '0, 1, 32'h80FF_0000, 1, 1, 1, 1,
                     wbw(1, 5'd9, 32'hFFFF_FF80, 32'h1008), 1, zp(0, 1, 5'd9, 32'hFFFF_FF80)));
      v.push_back(idle(1'b0, '0, 1'b0, 32'h0, 1'b0));
      // ld_hu off=2, data_ok under WB stall, released two cycles later
      v.push_back(idle(1'b1, exw(1'b1, LD_HU, 1'b1, 5'd10, 32'h3002, 32'h100C), 1'b0, 32'h0,
                       1'b0));
      w = wbw(1, 5'd10, 32'h0000_BEEF, 32'h100C);
      z = zp(0, 1, 5'd10, 32'h0000_BEEF);
      v.push_back(mk(0, 0, '0, 1, 32'hBEEF_1234, 0, 0, 1, 1, w, 1, z));
      v.push_back(mk(0, 0, '0, 0, 32'hDEAD_DEAD, 0, 0, 1, 1, w, 1, z));
      v.push_back(mk(0, 0, '0, 0, 32'hDEAD_DEAD, 1, 1, 1, 1, w, 1, z));
      v.push_back(idle(1'b0, '0, 1'b0, 32'h0, 1'b0));
      // Back-to-back: ld_h, ALU, ld_w
      v.push_back(idle(1'b1, exw(1'b1, LD_H, 1'b1, 5'd11, 32'h4000, 32'h1010), 1'b0, 32'h0, 1'b0));
      v.push_back(mk(0, 1, exw(1'b0, NOLD, 1'b1, 5'd12, 32'h5555_AAAA, 32'h1014), 1,
                     32'h0000_8001, 1, 1, 1, 1, wbw(1, 5'd11, 32'hFFFF_8001, 32'h1010),
                     1, zp(0, 1, 5'd11, 32'hFFFF_8001)));
      v.push_back(mk(0, 1, exw(1'b1, LD_W, 1'b1, 5'd13, 32'h6004, 32'h1018), 0, 32'h0, 1,
                     1, 1, 1, wbw(1, 5'd12, 32'h5555_AAAA, 32'h1014),
                     1, zp(0, 1, 5'd12, 32'h5555_AAAA)));
      v.push_back(mk(0, 0, '0, 1, 32'h1234_5678, 1, 1, 1, 1,
                     wbw(1, 5'd13, 32'h1234_5678, 32'h1018), 1, zp(0, 1, 5'd13, 32'h1234_5678)));
      v.push_back(idle(1'b0, '0, 1'b0, 32'h0, 1'b0));
      // Spurious data_ok: empty stage, non-load held
      v.push_back(idle(1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0));
      v.push_back(idle(1'b1, exw(1'b0, NOLD, 1'b0, 5'd3, 32'h77, 32'h1020), 1'b1, 32'hFFFF_FFFF,
                       1'b0));
      w = wbw(0, 5'd3, 32'h77, 32'h1020);
      z = zp(0, 0, 5'd3, 32'h77);
      v.push_back(mk(0, 0, '0, 1, 32'hAAAA_AAAA, 0, 0, 1, 1, w, 1, z));
      v.push_back(mk(0, 0, '0, 1, 32'hAAAA_AAAA, 1, 1, 1, 1, w, 1, z));
      // Reset mid-WAIT, then the stale response arrives
      v.push_back(idle(1'b1, exw(1'b1, LD_BU, 1'b1, 5'd14, 32'h7001, 32'h1024), 1'b0, 32'h0,
                       1'b0));
      v.push_back(mk(0, 0, '0, 0, 32'h0, 1, 0, 0, 0, '0, 1, zp(1, 1, 5'd14, 32'h0)));
      v.push_back(mk(1, 0, '0, 0, 32'h0, 1, 0, 0, 0, '0, 1, zp(1, 1, 5'd14, 32'h0)));
      v.push_back(idle(1'b0, '0, 1'b1, 32'h0000_AB00, 1'b1));
      v.push_back(idle(1'b0, '0, 1'b0, 32'h0, 1'b1));
      // Following load must wait for its own response
      v.push_back(idle(1'b1, exw(1'b1, LD_BU, 1'b1, 5'd15, 32'h7001, 32'h1028), 1'b0, 32'h0,
                       1'b1));
      v.push_back(mk(0, 0, '0, 0, 32'h0, 1, 0, 0, 0, '0, 1, zp(1, 1, 5'd15, 32'h0)));
      v.push_back(mk(0, 0, '0, 1, 32'h0000_AB00, 1, 1, 1, 1,
                     wbw(1, 5'd15, 32'h0000_00AB, 32'h1028), 1, zp(0, 1, 5'd15, 32'h0000_00AB)));
      v.push_back(idle(1'b0, '0, 1'b0, 32'h0, 1'b0));

      reset                 = 1'b1;
      bus.ex_to_mem_valid   = 1'b0;
      bus.ex_to_mem_wire    = '0;
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = '0;
      bus.wb_allowin        = 1'b1;
      repeat (2) @(posedge clk);

      foreach (v[i]) begin
         #1;
         reset                 = v[i].rst;
         bus.ex_to_mem_valid   = v[i].exv;
         bus.ex_to_mem_wire    = v[i].exw;
         bus.data_sram_data_ok = v[i].dok;
         bus.data_sram_rdata   = v[i].rd;
         bus.wb_allowin        = v[i].wba;
         @(negedge clk);
         check("mem_allowin", i, 70'(bus.mem_allowin), 70'(v[i].e_allow));
         check("mem_to_wb_valid", i, 70'(bus.mem_to_wb_valid), 70'(v[i].e_ov));
         if (v[i].chk_wire) check("mem_to_wb_wire", i, bus.mem_to_wb_wire, v[i].e_wire);
         ez = FWD ? v[i].e_zip : 39'b0;
         if (v[i].chk_zip || !FWD) check("mem_rf_zip", i, 70'(bus.mem_rf_zip), 70'(ez));
         @(posedge clk);
      end

      // ld_h off=2 with the response two cycles late, bounded wait for the handoff
      #1;
      reset               = 1'b0;
      bus.ex_to_mem_valid = 1'b1;
      bus.ex_to_mem_wire  = exw(1'b1, LD_H, 1'b1, 5'd17, 32'h8002, 32'h1030);
      bus.wb_allowin      = 1'b1;
      @(posedge clk);
      #1;
      bus.ex_to_mem_valid = 1'b0;
      bus.ex_to_mem_wire  = '0;
      stalls = 0;
      got    = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus.data_sram_data_ok = (c == 2);
         bus.data_sram_rdata   = (c == 2) ? 32'h8000_0000 : 32'h0;
         @(negedge clk);
         if (bus.mem_to_wb_valid) begin
            check("seq_wire", c, bus.mem_to_wb_wire, wbw(1, 5'd17, 32'hFFFF_8000, 32'h1030));
            got = 1'b1;
            break;
         end
         if (!bus.mem_allowin) stalls++;
         @(posedge clk);
         #1;
      end
      if (got) begin
         @(posedge clk);
         #1;
      end
      check("seq_handoff_seen", 0, 70'(got), 70'd1);
      check("seq_stall_cycles", 0, 70'(stalls), 70'd2);
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = '0;
      @(negedge clk);
      check("seq_after_handoff", 0, 70'(bus.mem_to_wb_valid), 70'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
